// File: rtl/multdiv_iter.sv
// Iterative RV32M multiply/divide unit that shares the EX-stage ALU adder.
// One operand latch, 32 add/sub steps, a sign fix-up, then a one-cycle result pulse.
module multdiv_iter #(
  parameter bit EARLY_DIVZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        kill_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [33:0] adder_result_ext_i,
  output logic [31:0] multdiv_operand_a_o,
  output logic [31:0] multdiv_operand_b_o,
  output logic        alu_req_o,
  output logic        alu_sub_o,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o
);

  typedef enum logic [2:0] {
    IDLE, PREP, ITER, FIX, DONE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] m_q, m_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;

  logic [31:0] sum;
  logic        carry;
  logic        is_div, divz;
  logic        sgn_a, sgn_b;
  logic [31:0] abs_a, abs_b;
  logic [31:0] quo, rem;
  logic [63:0] prod, prod_f;
  logic        qbit;
  logic        unused_lsb;

  assign sum        = adder_result_ext_i[32:1];
  assign carry      = adder_result_ext_i[33];
  assign unused_lsb = adder_result_ext_i[0];

  assign is_div = op_q[2];
  assign divz   = (b_q == 32'd0);
  assign sgn_a  = a_q[31] & ((op_q == 3'd1) | (op_q == 3'd2) |
                             (op_q == 3'd4) | (op_q == 3'd6));
  assign sgn_b  = b_q[31] & ((op_q == 3'd1) | (op_q == 3'd4) |
                             (op_q == 3'd6));
  assign abs_a  = sgn_a ? (32'd0 - a_q) : a_q;
  assign abs_b  = sgn_b ? (32'd0 - b_q) : b_q;

  // A zero divisor leaves the quotient at all-ones unsigned.
  assign prod   = {hi_q, lo_q};
  assign prod_f = (sgn_a ^ sgn_b) ? (64'd0 - prod) : prod;
  assign quo    = ((sgn_a ^ sgn_b) & ~divz) ? (32'd0 - lo_q) : lo_q;
  assign rem    = sgn_a ? (32'd0 - hi_q) : hi_q;
  assign qbit   = hi_q[31] | carry;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    alu_req_o           = 1'b0;
    alu_sub_o           = 1'b0;
    multdiv_operand_a_o = 32'd0;
    multdiv_operand_b_o = 32'd0;
    unique case (state_q)
      IDLE: begin
        if (en_i && !kill_i) begin
          state_d = PREP;
          op_d    = op_i;
          a_d     = rs1_i;
          b_d     = rs2_i;
        end
      end
      PREP: begin
        cnt_d = 5'd31;
        hi_d  = 32'd0;
        lo_d  = is_div ? abs_a : abs_b;
        m_d   = is_div ? abs_b : abs_a;
        if (is_div && divz && EARLY_DIVZERO) begin
          res_d   = op_q[1] ? a_q : 32'hFFFF_FFFF;
          state_d = DONE;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        alu_req_o           = 1'b1;
        multdiv_operand_b_o = m_q;
        if (is_div) begin
          alu_sub_o           = 1'b1;
          multdiv_operand_a_o = {hi_q[30:0], lo_q[31]};
          hi_d = qbit ? sum : {hi_q[30:0], lo_q[31]};
          lo_d = {lo_q[30:0], qbit};
        end else begin
          multdiv_operand_a_o = hi_q;
          if (lo_q[0]) begin
            hi_d = {carry, sum[31:1]};
            lo_d = {sum[0], lo_q[31:1]};
          end else begin
            hi_d = {1'b0, hi_q[31:1]};
            lo_d = {hi_q[0], lo_q[31:1]};
          end
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = FIX;
      end
      FIX: begin
        unique case (1'b1)
          (op_q == 3'd0):                  res_d = prod_f[31:0];
          (!op_q[2] && op_q[1:0] != 2'd0): res_d = prod_f[63:32];
          (op_q[2] && !op_q[1]):           res_d = quo;
          (op_q[2] && op_q[1]):            res_d = rem;
          default:                         res_d = res_q;
        endcase
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill_i && state_q != IDLE) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      m_q     <= 32'd0;
      cnt_q   <= 5'd0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = res_q;

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed bench for multdiv_iter with a behavioural ALU adder.
// Checks results, latency, ALU borrowing, kill, back-to-back and async reset.
module tb_multdiv_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_i = 1'b0;
  logic        kill_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] rs1_i = 32'd0;
  logic [31:0] rs2_i = 32'd0;
  logic [33:0] adder_ext;
  logic [31:0] opa, opb;
  logic        alu_req, alu_sub, busy, valid;
  logic [31:0] result;
  logic [32:0] alu_s;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign alu_s = alu_sub ? ({1'b0, opa} + {1'b0, ~opb} + 33'd1)
                         : ({1'b0, opa} + {1'b0, opb});
  assign adder_ext = {alu_s, 1'b0};

  multdiv_iter dut (
    .clk                 (clk),
    .rst                 (rst),
    .en_i                (en_i),
    .kill_i              (kill_i),
    .op_i                (op_i),
    .rs1_i               (rs1_i),
    .rs2_i               (rs2_i),
    .adder_result_ext_i  (adder_ext),
    .multdiv_operand_a_o (opa),
    .multdiv_operand_b_o (opb),
    .alu_req_o           (alu_req),
    .alu_sub_o           (alu_sub),
    .busy_o              (busy),
    .valid_o             (valid),
    .result_o            (result)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int cyc);
    int n, reqs, bad;
    n = 0; reqs = 0; bad = 0;
    @(negedge clk);
    en_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
    @(posedge clk);
    while (n < 100) begin
      @(negedge clk);
      en_i = 1'b0;
      n++;
      if (alu_req) reqs++;
      else if ((opa | opb) != 32'd0) bad++;
      if (valid) break;
    end
    chk(tag, result, exp);
    chk({tag, "_cyc"}, n, cyc);
    chk({tag, "_req"}, reqs, (cyc == 35) ? 32 : 0);
    chk({tag, "_opz"}, bad, 0);
  endtask

  initial begin
    int n, nv, v1, v2;
    #12;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_res", result, 0);
    chk("rst_req", {31'd0, alu_req}, 0);
    chk("rst_opa", opa | opb, 0);
    rst = 1'b1;

    run_op("mul",    3'd0, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
    run_op("mulhu",  3'd3, 32'h7, 32'hFFFF_FFFD, 32'h0000_0006, 35);
    run_op("mulh",   3'd1, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 35);
    run_op("mulhsu", 3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 35);
    run_op("mulh2",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
    run_op("divu",   3'd5, 32'd100, 32'd7, 32'd14, 35);
    run_op("remu",   3'd7, 32'd100, 32'd7, 32'd2, 35);
    run_op("divu0",  3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    run_op("rem0",   3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 2);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35);

    // kill in the middle of a multiply
    n = 0; nv = 0;
    @(negedge clk);
    en_i = 1'b1; op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd5;
    @(posedge clk);
    while (n < 45) begin
      @(negedge clk);
      en_i = 1'b0;
      n++;
      if (valid) nv++;
      if (n == 10) kill_i = 1'b1;
      if (n == 11) begin
        kill_i = 1'b0;
        chk("kill_busy", {31'd0, busy}, 0);
      end
    end
    chk("kill_nvalid", nv, 0);
    chk("kill_res", result, 32'h8000_0000);

    // kill and en together in IDLE
    @(negedge clk);
    en_i = 1'b1; kill_i = 1'b1;
    @(negedge clk);
    en_i = 1'b0; kill_i = 1'b0;
    chk("killen_busy", {31'd0, busy}, 0);

    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 35);

    // en held high: one accept per completion
    n = 0; nv = 0; v1 = 0; v2 = 0;
    @(negedge clk);
    en_i = 1'b1; op_i = 3'd5; rs1_i = 32'd100; rs2_i = 32'd7;
    @(posedge clk);
    while (n < 72) begin
      @(negedge clk);
      n++;
      if (valid) begin
        nv++;
        if (nv == 1) v1 = n;
        if (nv == 2) v2 = n;
      end
    end
    en_i = 1'b0;
    chk("b2b_nvalid", nv, 2);
    chk("b2b_first", v1, 35);
    chk("b2b_second", v2, 71);
    chk("b2b_res", result, 32'd14);
    repeat (40) @(negedge clk);

    // async reset in the middle of a divide
    n = 0;
    @(negedge clk);
    en_i = 1'b1; op_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd3;
    @(posedge clk);
    while (n < 20) begin
      @(negedge clk);
      en_i = 1'b0;
      n++;
    end
    chk("pre_rst_busy", {31'd0, busy}, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_valid", {31'd0, valid}, 0);
    chk("arst_res", result, 0);
    chk("arst_req", {31'd0, alu_req | alu_sub}, 0);
    chk("arst_opnd", opa | opb, 0);
    @(negedge clk);
    rst = 1'b1;
    run_op("divu93", 3'd5, 32'd9, 32'd3, 32'd3, 35);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
